// File: rtl/trail_stack_if.sv
// trail_stack_if: push/pop/mark/backtrack bus and status of trail_stack (peak_size under TRAIL_STACK_PEAK_EN)
interface trail_stack_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LEVELS = 16
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LEVELS + 1);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] top;
    logic              mark;
    logic              backtrack;
    logic [LW-1:0]     bt_level;
    logic              unwind_valid;
    logic [DATA_W-1:0] unwind_data;
    logic              busy;
    logic [SW-1:0]     size;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              err_overflow;
    logic              err_underflow;
`ifdef TRAIL_STACK_PEAK_EN
    logic [SW-1:0]     peak_size;
`endif
    modport master (
`ifdef TRAIL_STACK_PEAK_EN
        input peak_size,
`endif
        output push, push_data, pop, mark, backtrack, bt_level,
        input pop_data, pop_valid, top, unwind_valid, unwind_data, busy,
        input size, level, full, empty, err_overflow, err_underflow
    );
    modport slave (
`ifdef TRAIL_STACK_PEAK_EN
        output peak_size,
`endif
        input push, push_data, pop, mark, backtrack, bt_level,
        output pop_data, pop_valid, top, unwind_valid, unwind_data, busy,
        output size, level, full, empty, err_overflow, err_underflow
    );
endinterface

// File: rtl/trail_stack.sv
// trail_stack: LIFO trail with decision-level marks and backtrack unwind; TRAIL_STACK_PEAK_EN adds peak_size
module trail_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LEVELS = 16
) (
    input logic          clock,
    input logic          reset,
    trail_stack_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LEVELS + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SW-1:0] FULL_N = SW'(DEPTH);
    localparam logic [LW-1:0] LMAX = LW'(LEVELS);
    typedef enum logic {IDLE, UNWIND} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [SW-1:0]     marks [LEVELS+1];
    logic [SW-1:0]     size, target;
    logic [LW-1:0]     level, tgt_level;
    logic [AW-1:0]     top_idx;
    logic              empty, full;
    assign top_idx = AW'(size - 1'b1);
    assign empty = size == '0;
    assign full = size == FULL_N;
    assign bus.top = empty ? '0 : mem[top_idx];
    assign bus.size = size;
    assign bus.level = level;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.busy = state == UNWIND;
    // Stack, mark and unwind control; reset aborts an unwind in progress
    always_ff @(posedge clock) begin
        bus.pop_valid <= 1'b0;
        bus.unwind_valid <= 1'b0;
        if (reset) begin
            state <= IDLE;
            size <= '0;
            level <= '0;
            target <= '0;
            tgt_level <= '0;
            marks[0] <= '0;
            bus.pop_data <= '0;
            bus.unwind_data <= '0;
            bus.err_overflow <= 1'b0;
            bus.err_underflow <= 1'b0;
`ifdef TRAIL_STACK_PEAK_EN
            bus.peak_size <= '0;
`endif
        end else if (state == UNWIND) begin
            if (size > target) begin
                bus.unwind_data <= mem[top_idx];
                bus.unwind_valid <= 1'b1;
                size <= size - 1'b1;
            end else begin
                state <= IDLE;
                level <= tgt_level;
            end
        end else if (bus.backtrack && bus.bt_level < level) begin
            state <= UNWIND;
            target <= marks[bus.bt_level];
            tgt_level <= bus.bt_level;
        end else begin
            if (bus.backtrack) bus.err_underflow <= 1'b1;
            if (bus.push && bus.pop && !empty) begin
                mem[top_idx] <= bus.push_data;
                bus.pop_data <= mem[top_idx];
                bus.pop_valid <= 1'b1;
            end else if (bus.push) begin
                if (full) bus.err_overflow <= 1'b1;
                else begin
                    mem[AW'(size)] <= bus.push_data;
                    size <= size + 1'b1;
`ifdef TRAIL_STACK_PEAK_EN
                    if (size + 1'b1 > bus.peak_size) bus.peak_size <= size + 1'b1;
`endif
                end
            end else if (bus.pop) begin
                if (empty) bus.err_underflow <= 1'b1;
                else begin
                    bus.pop_data <= mem[top_idx];
                    bus.pop_valid <= 1'b1;
                    size <= size - 1'b1;
                end
            end
            if (bus.mark) begin
                if (level == LMAX) bus.err_overflow <= 1'b1;
                else begin
                    marks[level + 1'b1] <= size;
                    level <= level + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trail_stack.sv
// tb_trail_stack: directed self-checking bench for trail_stack (DATA_W=8, DEPTH=6, LEVELS=2)
module tb_trail_stack;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    trail_stack_if #(.DATA_W(8), .DEPTH(6), .LEVELS(2)) bus();
    trail_stack #(.DATA_W(8), .DEPTH(6), .LEVELS(2)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    // Free-running clock, period 10
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.mark = 1'b0;
        bus.backtrack = 1'b0;
        bus.push_data = '0;
        bus.bt_level = '0;
    endtask

    task automatic do_reset;
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] d);
        bus.push = 1'b1;
        bus.push_data = d;
        step();
        bus.push = 1'b0;
    endtask

    task automatic pop_one;
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
    endtask

    task automatic mark_one;
        bus.mark = 1'b1;
        step();
        bus.mark = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({bus.size, bus.level, bus.empty, bus.full, bus.busy} !== {3'd0, 2'd0, 3'b100}) begin
            errors++;
            $display("FAIL reset_state got %b want %b", {bus.size, bus.level, bus.empty, bus.full, bus.busy}, {3'd0, 2'd0, 3'b100});
        end
        checks++;
        if ({bus.top, bus.pop_data, bus.unwind_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 000000", {bus.top, bus.pop_data, bus.unwind_data});
        end
        checks++;
        if ({bus.pop_valid, bus.unwind_valid, bus.err_overflow, bus.err_underflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {bus.pop_valid, bus.unwind_valid, bus.err_overflow, bus.err_underflow});
        end
    endtask

    task automatic test_push_pop;
        do_reset();
        push_one(8'h0A);
        push_one(8'h0B);
        push_one(8'h0C);
        checks++;
        if ({bus.size, bus.top} !== {3'd3, 8'h0C}) begin
            errors++;
            $display("FAIL push3 got size %0d top %h want size 3 top 0c", bus.size, bus.top);
        end
        pop_one();
        checks++;
        if ({bus.pop_valid, bus.pop_data, bus.size, bus.top} !== {1'b1, 8'h0C, 3'd2, 8'h0B}) begin
            errors++;
            $display("FAIL pop got v %b d %h size %0d top %h want v 1 d 0c size 2 top 0b", bus.pop_valid, bus.pop_data, bus.size, bus.top);
        end
        step();
        checks++;
        if (bus.pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_strobe got %b want 0", bus.pop_valid);
        end
    endtask

    task automatic test_replace;
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.push_data = 8'h0D;
        step();
        clear_in();
        checks++;
        if ({bus.pop_valid, bus.pop_data, bus.size, bus.top, bus.err_underflow} !== {1'b1, 8'h0B, 3'd2, 8'h0D, 1'b0}) begin
            errors++;
            $display("FAIL replace got v %b d %h size %0d top %h uf %b want v 1 d 0b size 2 top 0d uf 0", bus.pop_valid, bus.pop_data, bus.size, bus.top, bus.err_underflow);
        end
    endtask

    task automatic test_full_empty;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            push_one(8'(i));
            if (i == 6) begin
                checks++;
                if ({bus.full, bus.size, bus.err_overflow} !== {1'b1, 3'd6, 1'b0}) begin
                    errors++;
                    $display("FAIL fill got full %b size %0d of %b want full 1 size 6 of 0", bus.full, bus.size, bus.err_overflow);
                end
            end
        end
        checks++;
        if ({bus.size, bus.full, bus.top, bus.err_overflow, bus.err_underflow} !== {3'd6, 1'b1, 8'h06, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL overflow got size %0d full %b top %h of %b uf %b want 6 1 06 1 0", bus.size, bus.full, bus.top, bus.err_overflow, bus.err_underflow);
        end
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.push_data = 8'h77;
        step();
        clear_in();
        checks++;
        if ({bus.pop_valid, bus.pop_data, bus.size, bus.top} !== {1'b1, 8'h06, 3'd6, 8'h77}) begin
            errors++;
            $display("FAIL replace_full got v %b d %h size %0d top %h want 1 06 6 77", bus.pop_valid, bus.pop_data, bus.size, bus.top);
        end
        for (int i = 0; i < 6; i++) pop_one();
        pop_one();
        checks++;
        if ({bus.pop_valid, bus.err_underflow, bus.empty, bus.size, bus.top} !== {1'b0, 1'b1, 1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL underflow got v %b uf %b empty %b size %0d top %h want 0 1 1 0 00", bus.pop_valid, bus.err_underflow, bus.empty, bus.size, bus.top);
        end
        do_reset();
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.push_data = 8'h09;
        step();
        clear_in();
        checks++;
        if ({bus.size, bus.top, bus.pop_valid, bus.err_underflow} !== {3'd1, 8'h09, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pushpop_empty got size %0d top %h v %b uf %b want 1 09 0 0", bus.size, bus.top, bus.pop_valid, bus.err_underflow);
        end
    endtask

    task automatic test_unwind;
        int nb, nu, first, last;
        logic [23:0] got;
        do_reset();
        push_one(8'h01);
        mark_one();
        push_one(8'h02);
        push_one(8'h03);
        mark_one();
        push_one(8'h04);
        checks++;
        if ({bus.size, bus.level} !== {3'd4, 2'd2}) begin
            errors++;
            $display("FAIL pre_unwind got size %0d level %0d want 4 2", bus.size, bus.level);
        end
        bus.backtrack = 1'b1;
        bus.bt_level = 2'd1;
        step();
        clear_in();
        nb = 0;
        nu = 0;
        first = -1;
        last = -1;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) nb++;
            if (bus.unwind_valid) begin
                got = {got[15:0], bus.unwind_data};
                nu++;
                if (first < 0) first = i;
                last = i;
            end
            bus.push = bus.busy;
            bus.push_data = 8'hEE;
            bus.mark = bus.busy;
            step();
        end
        clear_in();
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL unwind_busy got %0d cycles want 4", nb);
        end
        checks++;
        if (nu !== 3 || last - first !== 2) begin
            errors++;
            $display("FAIL unwind_strobes got %0d over span %0d want 3 over span 2", nu, last - first);
        end
        checks++;
        if (got !== 24'h040302) begin
            errors++;
            $display("FAIL unwind_data got %h want 040302", got);
        end
        checks++;
        if ({bus.size, bus.level, bus.top, bus.err_overflow, bus.err_underflow} !== {3'd1, 2'd1, 8'h01, 2'b00}) begin
            errors++;
            $display("FAIL post_unwind got size %0d level %0d top %h of %b uf %b want 1 1 01 0 0", bus.size, bus.level, bus.top, bus.err_overflow, bus.err_underflow);
        end
        mark_one();
        bus.backtrack = 1'b1;
        bus.bt_level = 2'd1;
        step();
        clear_in();
        nb = 0;
        nu = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.busy) nb++;
            if (bus.unwind_valid) nu++;
            step();
        end
        checks++;
        if ({nb, nu} !== {32'd1, 32'd0} || {bus.size, bus.level} !== {3'd1, 2'd1}) begin
            errors++;
            $display("FAIL empty_unwind got busy %0d strobes %0d size %0d level %0d want 1 0 1 1", nb, nu, bus.size, bus.level);
        end
    endtask

    task automatic test_errors;
        do_reset();
        mark_one();
        mark_one();
        checks++;
        if ({bus.level, bus.err_overflow} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL mark_max got level %0d of %b want 2 0", bus.level, bus.err_overflow);
        end
        mark_one();
        checks++;
        if ({bus.level, bus.err_overflow, bus.err_underflow} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mark_overflow got level %0d of %b uf %b want 2 1 0", bus.level, bus.err_overflow, bus.err_underflow);
        end
        bus.backtrack = 1'b1;
        bus.bt_level = 2'd2;
        bus.push = 1'b1;
        bus.push_data = 8'h05;
        step();
        clear_in();
        checks++;
        if ({bus.busy, bus.err_underflow, bus.size, bus.top} !== {1'b0, 1'b1, 3'd1, 8'h05}) begin
            errors++;
            $display("FAIL bt_bad got busy %b uf %b size %0d top %h want 0 1 1 05", bus.busy, bus.err_underflow, bus.size, bus.top);
        end
        step();
        checks++;
        if ({bus.busy, bus.level} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL bt_bad_idle got busy %b level %0d want 0 2", bus.busy, bus.level);
        end
        push_one(8'h06);
        push_one(8'h07);
        bus.backtrack = 1'b1;
        bus.bt_level = 2'd0;
        step();
        clear_in();
        step();
        checks++;
        if ({bus.busy, bus.unwind_valid, bus.unwind_data, bus.size} !== {1'b1, 1'b1, 8'h07, 3'd2}) begin
            errors++;
            $display("FAIL unwind_first got busy %b v %b d %h size %0d want 1 1 07 2", bus.busy, bus.unwind_valid, bus.unwind_data, bus.size);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.size, bus.level, bus.busy, bus.unwind_valid, bus.err_overflow, bus.err_underflow} !== {3'd0, 2'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_unwind got %b want 000000000", {bus.size, bus.level, bus.busy, bus.unwind_valid, bus.err_overflow, bus.err_underflow});
        end
    endtask

`ifdef TRAIL_STACK_PEAK_EN
    task automatic test_peak;
        do_reset();
        checks++;
        if (bus.peak_size !== 3'd0) begin
            errors++;
            $display("FAIL peak_reset got %0d want 0", bus.peak_size);
        end
        for (int i = 1; i <= 6; i++) push_one(8'(i));
        for (int i = 0; i < 4; i++) pop_one();
        push_one(8'h11);
        checks++;
        if ({bus.peak_size, bus.size} !== {3'd6, 3'd3}) begin
            errors++;
            $display("FAIL peak got peak %0d size %0d want 6 3", bus.peak_size, bus.size);
        end
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        clear_in();
        test_reset();
        test_push_pop();
        test_replace();
        test_full_empty();
        test_unwind();
        test_errors();
`ifdef TRAIL_STACK_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
